// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and bank constants for the data-memory port arbiter.
package mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [1:0] BANK_IMEM = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational (zero latency).
// On a tie the port that was not served last wins; no backpressure of its own.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_winner,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid == 2'b11) begin
            o_grant = i_last_winner ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_valid;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data memory's registered-read port between CPU (p0) and DMA (p1); owns the data-bus tristate.
// Write done 2 cycles after accept, read done 3 cycles; ready is held low until the done cycle.
module mem_port_arbiter #(
    parameter int ADDR_W       = mem_pkg::ADDR_W,
    parameter int DATA_W       = mem_pkg::DATA_W,
    parameter bit PROTECT_IMEM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    input  logic              imem_wp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_mode,
    inout  wire  [DATA_W-1:0] mem_data
);
    import mem_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_wm;
    logic              r_we;
    logic              r_err;
    logic              r_port;
    logic              r_last;
    logic              r_done0;
    logic              r_done1;
    logic              r_err0;
    logic              r_err1;

    logic [1:0]        w_grant;
    logic [1:0]        w_acc;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_prot;

    rr_arb2 u_rr_arb2 (
        .i_valid       ({p1_valid, p0_valid}),
        .i_last_winner (r_last),
        .o_grant       (w_grant)
    );

    assign p0_ready = (r_state == ST_IDLE) & w_grant[0];
    assign p1_ready = (r_state == ST_IDLE) & w_grant[1];
    assign w_acc    = {p1_valid & p1_ready, p0_valid & p0_ready};

    assign w_sel   = w_grant[1];
    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;
    // A blocked write still walks the write path so its timing matches a real one.
    assign w_prot  = PROTECT_IMEM & imem_wp & (w_addr[ADDR_W-1 -: 2] == BANK_IMEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_wm     <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_port   <= 1'b0;
            r_last   <= 1'b1;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_wm    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_acc) begin
                        r_addr  <= w_addr;
                        r_we    <= w_we;
                        r_wdata <= w_wdata;
                        r_err   <= w_we & w_prot;
                        r_wm    <= w_we & ~w_prot;
                        r_port  <= w_sel;
                        r_last  <= w_sel;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_we) begin
                        r_state <= ST_IDLE;
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                        r_err0  <= ~r_port & r_err;
                        r_err1  <= r_port & r_err;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (r_port) begin
                        r_rdata1 <= mem_data;
                    end else begin
                        r_rdata0 <= mem_data;
                    end
                    r_done0 <= ~r_port;
                    r_done1 <= r_port;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_address    = r_addr;
    assign mem_write_mode = r_wm;
    assign mem_data       = r_wm ? r_wdata : {DATA_W{1'bz}};

    assign p0_done  = r_done0;
    assign p1_done  = r_done1;
    assign p0_err   = r_err0;
    assign p1_err   = r_err1;
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter against a transaction-level model with a reference memory.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam bit PROT = 1'b1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_valid = 1'b0, p1_valid = 1'b0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          imem_wp = 1'b0;
    logic          p0_ready, p1_ready, p0_done, p1_done, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_write_mode;
    wire  [DW-1:0] mem_data;

    // Simple registered-read memory sitting on the shared bus.
    logic [DW-1:0] tb_mem [0:2047];
    logic [DW-1:0] mem_q = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROTECT_IMEM(PROT)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .imem_wp(imem_wp), .mem_address(mem_address), .mem_write_mode(mem_write_mode),
        .mem_data(mem_data)
    );

    assign mem_data = mem_write_mode ? {DW{1'bz}} : mem_q;

    always @(posedge clk) begin
        if (mem_write_mode) tb_mem[mem_address[AW-1:1]] <= mem_data;
        mem_q <= tb_mem[mem_address[AW-1:1]];
    end

    // Transaction-level model state.
    logic [DW-1:0] ref_mem [0:2047];
    req_t          rq0[$];
    req_t          rq1[$];
    req_t          cur[2];
    logic          req_v[2];
    int            m_busy, m_last, m_port;
    logic          m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [DW-1:0] exp_rdata[2];
    int            acc_cnt;
    int            done_seq[$];
    int            err_seen;
    int            n_cmp, n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_port = 0;
        m_we = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wd = '0; m_rd = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    task automatic run_cycle(input bit rnd, input bit rst_now);
        logic [1:0] exp_done;
        logic [1:0] exp_err;
        logic       exp_wm;
        int         win;
        @(negedge clk);
        exp_done = '0;
        exp_err  = '0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                exp_done[m_port] = 1'b1;
                exp_err[m_port]  = m_err;
                if (!m_we) exp_rdata[m_port] = m_rd;
            end
        end
        exp_wm = m_we && !m_err && (m_busy == 1);

        check_val("p0_done", p0_done, exp_done[0]);
        check_val("p1_done", p1_done, exp_done[1]);
        check_val("p0_err", p0_err, exp_err[0]);
        check_val("p1_err", p1_err, exp_err[1]);
        check_val("p0_rdata", p0_rdata, exp_rdata[0]);
        check_val("p1_rdata", p1_rdata, exp_rdata[1]);
        check_val("mem_address", mem_address, m_addr);
        check_val("mem_write_mode", mem_write_mode, exp_wm);
        if (exp_wm) check_val("bus_wdata", mem_data, m_wd);
        else        check_val("bus_released", mem_data, mem_q);
        if (p0_done) done_seq.push_back(0);
        if (p1_done) done_seq.push_back(1);
        if (p0_done && p0_err) err_seen++;

        for (int p = 0; p < 2; p++) begin
            if (!req_v[p]) begin
                if (p == 0 && rq0.size() > 0) begin
                    cur[0] = rq0.pop_front(); req_v[0] = 1'b1;
                end else if (p == 1 && rq1.size() > 0) begin
                    cur[1] = rq1.pop_front(); req_v[1] = 1'b1;
                end else if (rnd && $urandom_range(0, 2) == 0) begin
                    cur[p].we   = 1'($urandom_range(0, 1));
                    cur[p].addr = AW'(($urandom_range(0, 3) << 10) | $urandom_range(0, 31));
                    cur[p].wd   = DW'($urandom);
                    req_v[p]    = 1'b1;
                end
            end
        end
        if (rnd) imem_wp = 1'($urandom_range(0, 1));

        rst      = rst_now;
        p0_valid = req_v[0]; p0_we = cur[0].we; p0_addr = cur[0].addr; p0_wdata = cur[0].wd;
        p1_valid = req_v[1]; p1_we = cur[1].we; p1_addr = cur[1].addr; p1_wdata = cur[1].wd;
        #1;

        win = -1;
        if (!rst_now && m_busy == 0) begin
            if (req_v[0] && req_v[1]) win = (m_last == 0) ? 1 : 0;
            else if (req_v[0])        win = 0;
            else if (req_v[1])        win = 1;
        end
        if (!rst_now) begin
            check_val("p0_ready", p0_ready, win == 0);
            check_val("p1_ready", p1_ready, win == 1);
        end

        if (rst_now) begin
            model_reset();
        end else if (win >= 0) begin
            m_last = win;
            m_port = win;
            m_we   = cur[win].we;
            m_addr = cur[win].addr;
            m_wd   = cur[win].wd;
            m_err  = m_we && PROT && imem_wp && (m_addr[AW-1:AW-2] == 2'b00);
            m_busy = m_we ? 2 : 3;
            if (m_we && !m_err) ref_mem[m_addr[AW-1:1]] = m_wd;
            if (!m_we) m_rd = ref_mem[m_addr[AW-1:1]];
            req_v[win] = 1'b0;
            acc_cnt++;
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] old_val;
        int            base;
        n_cmp = 0; n_err = 0; acc_cnt = 0; err_seen = 0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        cur[0] = req_t'{1'b0, '0, '0};
        cur[1] = req_t'{1'b0, '0, '0};
        for (int i = 0; i < 2048; i++) begin
            w = DW'($urandom);
            tb_mem[i]  = w;
            ref_mem[i] = w;
        end
        model_reset();
        repeat (3) @(posedge clk);

        // Write then read back on p0; first run_cycle also checks reset values.
        rq0.push_back(req_t'{1'b1, 12'h402, 16'h1234});
        rq0.push_back(req_t'{1'b0, 12'h402, 16'h0000});
        repeat (10) run_cycle(1'b0, 1'b0);
        check_val("t1_rdata", p0_rdata, 16'h1234);
        check_val("t1_accepts", acc_cnt, 2);

        // Tie from reset: both ports write twice, expect alternation starting at p0.
        run_cycle(1'b0, 1'b1);
        done_seq.delete();
        rq0.push_back(req_t'{1'b1, 12'h802, 16'h1111});
        rq0.push_back(req_t'{1'b1, 12'h806, 16'h2222});
        rq1.push_back(req_t'{1'b1, 12'hC02, 16'h3333});
        rq1.push_back(req_t'{1'b1, 12'hC06, 16'h4444});
        repeat (12) run_cycle(1'b0, 1'b0);
        check_val("t2_done_count", done_seq.size(), 4);
        for (int k = 0; k < 4; k++)
            check_val("t2_order", (k < done_seq.size()) ? done_seq[k] : -1, k % 2);

        // Preloaded read on p1 at top of address space.
        tb_mem[11'h7FE]  = 16'hABCD;
        ref_mem[11'h7FE] = 16'hABCD;
        rq1.push_back(req_t'{1'b0, 12'hFFC, 16'h0000});
        repeat (6) run_cycle(1'b0, 1'b0);
        check_val("t3_rdata", p1_rdata, 16'hABCD);

        // Protected write into bank 00, then the same write unprotected.
        old_val = ref_mem[2];
        imem_wp = 1'b1;
        err_seen = 0;
        rq0.push_back(req_t'{1'b1, 12'h004, 16'hBEEF});
        rq0.push_back(req_t'{1'b0, 12'h004, 16'h0000});
        repeat (8) run_cycle(1'b0, 1'b0);
        check_val("t4_err_seen", err_seen, 1);
        check_val("t4_old_value", p0_rdata, old_val);
        imem_wp = 1'b0;
        rq0.push_back(req_t'{1'b1, 12'h004, 16'hBEEF});
        rq0.push_back(req_t'{1'b0, 12'h004, 16'h0000});
        repeat (8) run_cycle(1'b0, 1'b0);
        check_val("t4_err_after", err_seen, 1);
        check_val("t4_new_value", p0_rdata, 16'hBEEF);

        // Reset during the ACCESS cycle of a write; data equals old contents so either outcome is consistent.
        base = acc_cnt;
        rq0.push_back(req_t'{1'b1, 12'h010, ref_mem[8]});
        for (int k = 0; k < 10 && acc_cnt == base; k++) run_cycle(1'b0, 1'b0);
        check_val("t5_accepted", acc_cnt - base, 1);
        done_seq.delete();
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b0, 1'b0);
        check_val("t5_no_done", done_seq.size(), 0);
        check_val("t5_wm_low", mem_write_mode, 1'b0);
        rq0.push_back(req_t'{1'b0, 12'h010, 16'h0000});
        repeat (6) run_cycle(1'b0, 1'b0);
        check_val("t5_post_accepts", acc_cnt - base, 2);
        check_val("t5_rdata", p0_rdata, ref_mem[8]);

        // Random traffic on both ports, then drain.
        repeat (3000) run_cycle(1'b1, 1'b0);
        repeat (12) run_cycle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the data memory's single read/write port (12-bit address bus, bidirectional 16-bit data bus, write_mode strobe) between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/loader). The block sequences each access to the memory's registered-read timing and owns the tristate drive of the data bus. It grants round-robin on contention and optionally blocks writes into the instruction region (address[11:10] = 00). It sits between the requesters and the memory; the memory's instruction-fetch port is untouched.

## Interface
- ADDR_W, 12, byte address width; bit 0 is ignored by memory, and [11:10] select the 1 KB bank
- DATA_W, 16, word width
- PROTECT_IMEM, 1, enables write protection of bank 00 under imem_wp
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- p0_valid / p1_valid  input  1  request valid
- p0_ready / p1_ready  output  1  combinational; high only in IDLE for the current winner
- p0_we / p1_we  input  1  1 = write, 0 = read
- p0_addr / p1_addr  input  ADDR_W  access address
- p0_wdata / p1_wdata  input  DATA_W  write data
- p0_done / p1_done  output  1  one-cycle completion pulse
- p0_rdata / p1_rdata  output  DATA_W  read data; valid while the matching done is high and held until the next read on that port
- p0_err / p1_err  output  1  qualifies done; the write was blocked by protection
- imem_wp  input  1  write-protect enable for bank 00
- mem_address  output  ADDR_W  drives the memory address bus
- mem_write_mode  output  1  drives memory write_mode
- mem_data  inout  DATA_W  memory data bus; driven only while mem_write_mode = 1, otherwise 'bz

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: address and mode are presented to memory.
  - CAPTURE: read data is on the bus.
- Arbitration is evaluated in IDLE only.
  - A single valid port wins.
  - If both ports are valid, the port that was not served last wins.
  - last_winner resets to 1, so port 0 wins the first tie.
- A transaction is accepted at the edge where px_valid && px_ready. At that edge:
  - addr, we and wdata are latched into mem_address, mem_write_mode and the wdata register.
  - last_winner updates.
  - State moves to ACCESS.
- ACCESS:
  - If we = 1, mem_data drives wdata. The memory writes at the end of this cycle. Next state is IDLE, and done pulses in the following cycle.
  - If we = 0, the memory latches its read data at the end of this cycle. Next state is CAPTURE.
- CAPTURE:
  - mem_data is sampled into px_rdata at the end of the cycle.
  - Next state is IDLE, and done pulses in the following cycle.
- Protected write (PROTECT_IMEM && imem_wp && addr[11:10] = 00):
  - Follows the same state path and timing as a normal write.
  - mem_write_mode stays 0 and mem_data is not driven.
  - done pulses with err = 1.
- Outside ACCESS of a write, mem_write_mode = 0 and mem_data = 'bz. Idle bus cycles therefore perform harmless reads.
- mem_address holds its last value when idle.

## Timing
- Reset values:
  - state = IDLE
  - mem_address = 0, mem_write_mode = 0, mem_data released
  - all done and err outputs = 0, all rdata = 0
  - last_winner = 1
- Latency from the accept edge E0:
  - Write: memory update at E1, done high in the cycle after E1.
  - Read: memory latch at E1, rdata captured at E2, done high in the cycle after E2.
- Throughput:
  - One write per 2 cycles, one read per 3 cycles.
  - A new accept can occur at the edge that ends the done cycle.
- ready is low in ACCESS and CAPTURE. valid may stay high while waiting; inputs must be stable while valid && !ready.
- The loser of a tie keeps valid high and is guaranteed service on the next IDLE accept. There is no starvation.
- Reset mid-transaction aborts it:
  - No done is issued.
  - mem_write_mode falls in the cycle after the reset edge.
  - A write aborted in ACCESS may or may not complete in memory.
- done is asserted for exactly one cycle and only on the port that was served.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W, DATA_W
  - the state enum (IDLE, ACCESS, CAPTURE)
  - bank constant BANK_IMEM = 2'b00
- Natural sub-module: rr_arb2, a 2-way round-robin grant (inputs: valids, last_winner; output: one-hot grant). It is purely combinational; the state register stays in the top.

## Test plan
- p0 write addr 0x402 data 0x1234, then p0 read 0x402 → write done 2 cycles after accept; read done 3 cycles after accept with rdata 0x1234.
- p0 and p1 valid together from reset, both writing, repeated twice → service order p0, p1, p0, p1; each done only on its own port.
- p1 read 0xFFC after preloading memory → p1_rdata = 0xABCD with p1_done; p0_done stays 0.
- imem_wp = 1 with p0 write 0x004 data 0xBEEF → p0_done with p0_err = 1; mem_write_mode never rises; a read of 0x004 returns the old value. Repeat with imem_wp = 0 → write lands and err = 0.
- rst asserted in the cycle after a write accept → no done issued; state is IDLE; mem_data is 'bz the cycle after reset; the next p0 request is accepted normally.
- Bus check across all scenarios: mem_data is non-Z from the arbiter only while mem_write_mode = 1 (no contention).
